// File: rtl/shifter_pkg.sv
// Shared types and constants for the registered 32-bit shifter.
// Optional rotate-right support is enabled with SHIFTER_ROR_EN.
package shifter_pkg;

    localparam int SH_WIDTH = 32;
    localparam int SH_AMT_W = 5;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_ROR = 2'b01,
        SH_SRL = 2'b10,
        SH_SRA = 2'b11
    } shift_funct_t;

    function automatic logic [SH_WIDTH-1:0] bit_rev(
        input logic [SH_WIDTH-1:0] v
    );
        logic [SH_WIDTH-1:0] r;
        for (int i = 0; i < SH_WIDTH; i++) begin
            r[i] = v[SH_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational log barrel shifter: right-shift core with bit reversal for SLL.
// With SHIFTER_ROR_EN, funct 01 rotates right; otherwise it passes a through.
module shift_core
    import shifter_pkg::*;
(
    input  shift_funct_t        funct,
    input  logic [SH_WIDTH-1:0] a,
    input  logic [SH_AMT_W-1:0] N,
    output logic [SH_WIDTH-1:0] y
);

    logic                           left;
    logic                           fill;
    logic [SH_AMT_W:0][SH_WIDTH-1:0] st;

    assign left  = (funct == SH_SLL);
    assign fill  = (funct == SH_SRA) & a[SH_WIDTH-1];
    assign st[0] = left ? bit_rev(a) : a;

    for (genvar i = 0; i < SH_AMT_W; i++) begin : g_stage
        localparam int S = 1 << i;
        logic [S-1:0] fill_bits;
`ifdef SHIFTER_ROR_EN
        // Rotation recirculates the bits that fall off the bottom
        assign fill_bits = (funct == SH_ROR) ? st[i][S-1:0] : {S{fill}};
`else
        assign fill_bits = {S{fill}};
`endif
        assign st[i+1] = N[i] ? {fill_bits, st[i][SH_WIDTH-1:S]} : st[i];
    end

    always_comb begin
        y = st[SH_AMT_W];
        if (left) begin
            y = bit_rev(st[SH_AMT_W]);
        end
`ifndef SHIFTER_ROR_EN
        else if (funct == SH_ROR) begin
            y = a;
        end
`endif
    end

endmodule

// File: rtl/shifter.sv
// Registered 32-bit shifter (SLL/SRL/SRA, funct 01 set by SHIFTER_ROR_EN).
// One-cycle latency, asynchronous active-high reset clears R.
module shifter
    import shifter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          funct,
    input  logic [SH_WIDTH-1:0] a,
    input  logic [SH_AMT_W-1:0] N,
    output logic [SH_WIDTH-1:0] R
);

    logic [SH_WIDTH-1:0] y;

    shift_core u_core (
        .funct (shift_funct_t'(funct)),
        .a     (a),
        .N     (N),
        .y     (y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            R <= '0;
        end else begin
            R <= y;
        end
    end

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: directed plan vectors plus random
// back-to-back operations against an arithmetic reference model.
module tb_shifter;

    logic        clk;
    logic        rst;
    logic [1:0]  funct;
    logic [31:0] a;
    logic [4:0]  N;
    logic [31:0] R;

    int checks = 0;
    int errors = 0;

    shifter dut (
        .clk   (clk),
        .rst   (rst),
        .funct (funct),
        .a     (a),
        .N     (N),
        .R     (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(
        input logic [1:0] f, input logic [31:0] x, input int n
    );
        logic [63:0] dbl;
        case (f)
            2'b00: return x << n;
            2'b10: return x >> n;
            2'b11: return 32'($signed(x) >>> n);
            default: begin
`ifdef SHIFTER_ROR_EN
                dbl = {x, x} >> n;
                return dbl[31:0];
`else
                dbl = '0;
                return x + dbl[31:0];
`endif
            end
        endcase
    endfunction

    task automatic check(
        input string tag, input logic [31:0] obs, input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one operation between edges, check R after the next edge
    task automatic step(
        input string tag, input logic [1:0] f, input logic [31:0] x,
        input logic [4:0] n, input logic [31:0] exp
    );
        @(negedge clk);
        funct = f;
        a     = x;
        N     = n;
        @(posedge clk);
        #1;
        check(tag, R, exp);
        check({tag, "_model"}, R, model(f, x, int'(n)));
    endtask

    logic [31:0] ror_exp;
    logic [1:0]  rf;
    logic [31:0] ra;
    logic [4:0]  rn;

    initial begin
`ifdef SHIFTER_ROR_EN
        ror_exp = 32'hC000_000C;
`else
        ror_exp = 32'h0000_00CC;
`endif
        funct = 2'b11;
        a     = 32'hFFFF_FFFF;
        N     = 5'd0;
        rst   = 1'b1;
        #1;
        check("reset_immediate", R, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", R, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", R, 32'hFFFF_FFFF);

        step("sll",       2'b00, 32'h0000_00CC, 5'd2,  32'h0000_0330);
        step("srl",       2'b10, 32'h0000_00CC, 5'd3,  32'h0000_0019);
        step("sra_pos",   2'b11, 32'h0000_00CC, 5'd4,  32'h0000_000C);
        step("sra_neg",   2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000);
        step("srl_neg",   2'b10, 32'h8000_0000, 5'd4,  32'h0800_0000);
        step("n0_sll",    2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        step("n0_ror",    2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        step("n0_srl",    2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        step("n0_sra",    2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        step("n31_sll",   2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        step("n31_sra",   2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        step("n31_srl",   2'b10, 32'h8000_0000, 5'd31, 32'h0000_0001);
        step("funct01",   2'b01, 32'h0000_00CC, 5'd4,  ror_exp);

        // Asynchronous reset mid-stream discards the held result
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_midstream", R, 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        funct = 2'b00;
        a     = 32'h1234_5678;
        N     = 5'd4;
        @(posedge clk);
        #1;
        check("reset_recover", R, 32'h2345_6780);

        // Back-to-back random operations, one result per cycle
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rf    = 2'($urandom_range(0, 3));
            ra    = $urandom;
            rn    = 5'($urandom_range(0, 31));
            funct = rf;
            a     = ra;
            N     = rn;
            @(posedge clk);
            #1;
            check("random", R, model(rf, ra, int'(rn)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter.md
# shifter

32-bit registered shifter for the datapath's ALU/shift unit. Each clock it shifts operand `a` by `N` bit positions: logical left, logical right or arithmetic right, selected by a 2-bit function code. The result is registered and drives `R` one cycle later. It is a leaf block with no handshake; the surrounding datapath holds or changes operands every cycle.

## Interface
Parameters: none. Width is fixed at 32 bits and shift amount at 5 bits.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `funct`  in  2  operation select: 00 SLL, 10 SRL, 11 SRA, 01 see Configuration.
- `a`  in  32  operand to be shifted.
- `N`  in  5  shift amount, 0–31, unsigned.
- `R`  out  32  registered result.

## Operation
- SLL (00): `R <= a << N`, zeros fill LSBs.
- SRL (10): `R <= a >> N`, zeros fill MSBs.
- SRA (11): `R <= a >>> N`, `a[31]` replicated into MSBs.
- 01 without `SHIFTER_ROR_EN`: `R <= a`, pass-through with no shift.
- Shift amount:
  - `N=0` returns `a` unchanged for every funct.
  - `N=31` is the maximum; no amount ≥32 is representable.
- Result is exactly 32 bits; bits shifted out are discarded.
- No flags and no carry-out.
- Implementation is a logarithmic barrel shifter: 5 stages shifting by 1, 2, 4, 8 and 16, each stage enabled by the corresponding bit of `N`.
- Left shift is realised by bit-reversing the input and output around a right-shift core.
- The fill bit is `a[31]` for SRA and 0 otherwise.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge k appear on `R` after edge k. The path is fully combinational up to the output register.
- Throughput: one new operation per cycle. Changing inputs every cycle yields one result per cycle.
- Reset:
  - `rst=1` forces `R=32'h0000_0000` immediately, without waiting for a clock edge.
  - `R` stays 0 while `rst` is held.
  - The first edge after deassertion captures the current inputs.
- Reset asserted mid-stream: the in-flight result is discarded and `R` goes to 0 asynchronously.
- `R` is never X after reset, even if inputs were X before reset.

## Configuration
- `SHIFTER_ROR_EN` defined: funct 01 is rotate right. `R <= (a >> N) | (a << (32-N))`; `N=0` gives `a`.
- `SHIFTER_ROR_EN` undefined: funct 01 is a pass-through (`R <= a`) and no rotate logic is built.
- SLL, SRL and SRA behave identically in both builds.

## Structure
- Package `shifter_pkg` holds:
  - typedef `shift_funct_t` (2-bit enum: `SH_SLL=2'b00`, `SH_ROR=2'b01`, `SH_SRL=2'b10`, `SH_SRA=2'b11`);
  - constants `SH_WIDTH=32` and `SH_AMT_W=5`.
- One combinational sub-module, `shift_core`. It contains the 5-stage barrel shifter, direction reversal and fill logic.
- The top level `shifter` instantiates `shift_core` and adds the asynchronously reset output register.

## Test plan
- Reset: assert `rst` with `a=32'hFFFF_FFFF`, `funct=11` → `R=0` immediately and while held; after release and one edge `R=32'hFFFF_FFFF`.
- SLL: `funct=00`, `a=32'h0000_00CC`, `N=2` → `R=32'h0000_0330` one cycle later.
- SRL: `funct=10`, `a=32'h0000_00CC`, `N=3` → `R=32'h0000_0019`. SRA, positive operand: `funct=11`, `a=32'h0000_00CC`, `N=4` → `R=32'h0000_000C`.
- SRA, negative operand: `funct=11`, `a=32'h8000_0000`, `N=4` → `R=32'hF800_0000`; same operand with `funct=10` → `32'h0800_0000`.
- Boundaries:
  - `N=0`, any funct, `a=32'hDEAD_BEEF` → `R=32'hDEAD_BEEF`;
  - `N=31`, `funct=00`, `a=1` → `32'h8000_0000`;
  - `N=31`, `funct=11`, `a=32'h8000_0000` → `32'hFFFF_FFFF`.
- funct 01, `a=32'h0000_00CC`, `N=4`:
  - with `SHIFTER_ROR_EN` → `R=32'hC000_000C`;
  - without it → `32'h0000_00CC`.
  - Back-to-back changes every cycle yield one correct result per cycle.
